multiplier: RTL and testbench

MULTIPLIER -- requirements
Module: multiplier

---
 rtl/multiplier_pkg.sv | 11 +
 rtl/multiplier_approx_mul_core.sv | 37 +++
 rtl/multiplier.sv | 55 +++++
 tb/tb_multiplier.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/multiplier_pkg.sv
// Shared widths and types for the approximate 4x4 multiplier.
package multiplier_pkg;
    localparam int unsigned OP_W        = 4;
    localparam int unsigned PROD_W      = 8;
    localparam int unsigned ERR_W       = 4;
    localparam int unsigned APPROX_COLS = 3;

    typedef logic [OP_W-1:0]   op_t;
    typedef logic [PROD_W-1:0] prod_t;
    typedef logic [ERR_W-1:0]  err_t;
endpackage

// File: rtl/multiplier_approx_mul_core.sv
// Combinational approximate multiplier core: the low APPROX_COLS columns
// OR their partial products (no carries); higher columns are summed exactly.
module approx_mul_core
    import multiplier_pkg::*;
(
    input  logic [OP_W-1:0]   i_a,
    input  logic [OP_W-1:0]   i_b,
    output logic [PROD_W-1:0] o_approx,
    output logic [PROD_W-1:0] o_exact
);

    logic [PROD_W-1:0] w_low;
    logic [PROD_W-1:0] w_high;
    logic [PROD_W-1:0] w_pp;

    // Partial-product reduction: OR into low columns, add into the high part.
    // OR-ing a shifted single bit into w_low is equivalent to a per-column OR.
    always_comb begin
        w_low  = '0;
        w_high = '0;
        w_pp   = '0;
        for (int unsigned i = 0; i < OP_W; i++) begin
            for (int unsigned j = 0; j < OP_W; j++) begin
                w_pp = prod_t'(i_a[j] & i_b[i]) << (i + j);
                if ((i + j) < APPROX_COLS) begin
                    w_low = w_low | w_pp;
                end else begin
                    w_high = w_high + w_pp;
                end
            end
        end
    end

    assign o_approx = w_high + w_low;
    assign o_exact  = prod_t'(i_a) * prod_t'(i_b);

endmodule

// File: rtl/multiplier.sv
// Approximate multiplier top: combinational product plus a one-cycle
// registered product, error and valid flag.
module multiplier
    import multiplier_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OP_W-1:0]   A,
    input  logic [OP_W-1:0]   B,
    input  logic              in_valid,
    output logic [PROD_W-1:0] result,
    output logic [PROD_W-1:0] result_q,
    output logic [ERR_W-1:0]  err_q,
    output logic              out_valid
);

    logic [PROD_W-1:0] w_approx;
    logic [PROD_W-1:0] w_exact;
    logic [ERR_W-1:0]  w_err;

    logic [PROD_W-1:0] r_result_q;
    logic [ERR_W-1:0]  r_err_q;
    logic              r_out_valid;

    approx_mul_core u_core (
        .i_a      (A),
        .i_b      (B),
        .o_approx (w_approx),
        .o_exact  (w_exact)
    );

    // Error never exceeds 10, so it always fits the narrow field.
    assign w_err = err_t'(w_exact - w_approx);

    // Output registers: load on valid input, valid flag follows in_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result_q  <= '0;
            r_err_q     <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_result_q <= w_approx;
                r_err_q    <= w_err;
            end
        end
    end

    assign result    = w_approx;
    assign result_q  = r_result_q;
    assign err_q     = r_err_q;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for the approximate multiplier: directed cases,
// exhaustive sweep, async reset mid-stream and randomized traffic.
module tb_multiplier;

    logic       clk;
    logic       rst_n;
    logic [3:0] A;
    logic [3:0] B;
    logic       in_valid;
    logic [7:0] result;
    logic [7:0] result_q;
    logic [3:0] err_q;
    logic       out_valid;

    int n_cmp;
    int n_err;

    // Registered-path expectations
    int m_rq;
    int m_eq;
    int m_ov;

    real rel_sum;

    multiplier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .in_valid  (in_valid),
        .result    (result),
        .result_q  (result_q),
        .err_q     (err_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0d required=%0d", tag, obs, exp);
        end
    endtask

    // Reference: exact product with the low-column partial-product sums
    // replaced by "any product present" flags per column.
    function automatic int ref_approx(input int a, input int b);
        int cnt [3];
        int low_exact;
        int low_or;
        for (int k = 0; k < 3; k++) cnt[k] = 0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (i + j < 3 && ((a >> j) & 1) == 1 && ((b >> i) & 1) == 1)
                    cnt[i + j]++;
        low_exact = cnt[0] + 2 * cnt[1] + 4 * cnt[2];
        low_or    = (cnt[0] > 0 ? 1 : 0) + (cnt[1] > 0 ? 2 : 0) + (cnt[2] > 0 ? 4 : 0);
        return a * b - low_exact + low_or;
    endfunction

    task automatic step(input int a, input int b, input int v);
        int r;
        @(negedge clk);
        A        = 4'(a);
        B        = 4'(b);
        in_valid = v[0];
        r        = ref_approx(a, b);
        #1;
        check("comb_result", int'(result), r);
        @(posedge clk);
        if (v != 0) begin
            m_rq = r;
            m_eq = a * b - r;
        end
        m_ov = v;
        #1;
        check("result_q", int'(result_q), m_rq);
        check("err_q", int'(err_q), m_eq);
        check("out_valid", int'(out_valid), m_ov);
    endtask

    task automatic comb_const(input int a, input int b, input int exp);
        A = 4'(a);
        B = 4'(b);
        #1;
        check("directed_result", int'(result), exp);
    endtask

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        m_rq     = 0;
        m_eq     = 0;
        m_ov     = 0;
        rel_sum  = 0.0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        A        = 4'd3;
        B        = 4'd3;

        // Reset state and combinational path during reset
        #7;
        check("rst_result_q", int'(result_q), 0);
        check("rst_err_q", int'(err_q), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_comb", int'(result), 7);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed combinational values
        comb_const(3, 3, 7);
        comb_const(15, 15, 215);
        comb_const(7, 7, 39);
        comb_const(5, 3, 15);
        comb_const(1, 15, 15);
        comb_const(2, 2, 4);
        comb_const(0, 9, 0);

        // Directed registered: A=B=3 gives err 2, valid one edge later
        step(3, 3, 1);
        check("dir33_err_q", int'(err_q), 2);
        check("dir33_ov", int'(out_valid), 1);
        step(15, 15, 1);
        check("dir1515_err_q", int'(err_q), 10);
        step(7, 7, 1);
        check("dir77_err_q", int'(err_q), 10);

        // Exhaustive sweep with error-bound checks
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                step(a, b, 1);
                check("bound_le", (int'(result) <= a * b) ? 1 : 0, 1);
                check("bound_err", (a * b - int'(result) <= 10) ? 1 : 0, 1);
                if (a <= 1 || b <= 1)
                    check("exact_small", int'(result), a * b);
                if (a * b != 0)
                    rel_sum += real'(a * b - int'(result)) / real'(a * b);
            end
        end
        $display("mean relative error (sum over nonzero / 256) = %f", rel_sum / 256.0);

        // in_valid toggling 1,0,1: hold during the gap
        step(9, 6, 1);
        step(13, 11, 0);
        check("gap_hold", int'(result_q), ref_approx(9, 6));
        step(4, 12, 1);

        // Async reset between edges, then restart mid-stream
        step(11, 14, 1);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        m_rq = 0;
        m_eq = 0;
        m_ov = 0;
        check("async_result_q", int'(result_q), 0);
        check("async_err_q", int'(err_q), 0);
        check("async_out_valid", int'(out_valid), 0);
        rst_n = 1'b1;
        step(15, 15, 1);
        check("post_rst_rq", int'(result_q), 215);
        check("post_rst_ov", int'(out_valid), 1);

        // Randomized traffic
        for (int n = 0; n < 300; n++)
            step(int'($urandom_range(15)), int'($urandom_range(15)),
                 ($urandom_range(3) != 0) ? 1 : 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
